tape_recorder: RTL and testbench
================================

Name: tape_recorder

Overview:
- Cassette save path, the counterpart of the cassette loader. It watches the CPU tape-output level and the motor bit, and measures full-cycle periods of that waveform.
- Periods are classified into leader, zero, one and gap. Bits are assembled into bytes and stored in an internal buffer.
- The buffer is exposed to the HPS through the ioctl upload read port, so a saved program can be written out to a tape file.
- Sits at top level beside the cassette loader, clocked by the system clock and paced by the 4 MHz CPU enable.

Parameters:
- AW, 16, buffer address width; capacity is 2^AW bytes.
- MIN_T, 200, shortest valid period in ce ticks; anything shorter is a glitch.
- ZERO_MAX, 2400, a period below this (and at least MIN_T) is a 0 bit.
- ONE_MAX, 4800, a period below this (and at least ZERO_MAX) is a 1 bit; a period at or above it is a gap.
- LEADER_N, 256, number of consecutive 0 periods needed to qualify a leader.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- ce  in  1  CPU clock enable (4 MHz).
- mic  in  1  tape output level from CPU port logic; asynchronous to ce.
- motor  in  1  cassette motor bit; high means recording is armed.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_addr  in  25  upload byte address.
- ioctl_din  out  8  buffer byte at ioctl_addr.
- save_len  out  AW+1  number of bytes captured.
- save_done  out  1  a block ended on a gap.
- overflow  out  1  the buffer filled and bytes were dropped.

Behaviour:
- Reset (async, active-low): state goes to IDLE. save_len=0, save_done=0, overflow=0, ioctl_din=0. Counters and shift register clear.
- mic passes through a 2-flop synchronizer on clock. A rising edge is detected only on a ce cycle, comparing the synced level with its value on the previous ce.
- Period counter:
  - 16-bit, increments on each ce and saturates at 0xFFFF.
  - On every rising edge it is sampled into the classifier, then cleared.
  - If the count reaches ONE_MAX with no edge, a gap event fires once and is re-armed by the next edge.
- Classification, one clock after the edge: GLITCH if p<MIN_T (ignored, counter not cleared); ZERO if p<ZERO_MAX; ONE if p<ONE_MAX; GAP otherwise.
- States:
  - IDLE: on a motor rising edge, clear save_len, save_done and overflow, zero the leader count, go to LEADER.
  - LEADER:
    - ZERO increments the leader count, saturating at LEADER_N.
    - ONE with count ≥ LEADER_N goes to DATA; that ONE is the sync mark and is not stored.
    - ONE with count < LEADER_N, or GAP, resets the count.
  - DATA:
    - ZERO or ONE shifts into the byte register, MSB first.
    - On the 8th bit the byte is written to buffer[save_len] and save_len increments, both on the same clock.
    - GAP goes to DONE; a partial byte is discarded.
  - DONE: save_done=1. A later leader on the same motor session re-enters LEADER: a ZERO moves to LEADER with the leader count set to 1. New blocks append after save_len; save_done stays 1.
  - Any state: motor low returns to IDLE. The buffer and save_len are retained.
- Overflow: a write when save_len = 2^AW is dropped, overflow=1 (sticky until the next motor rising edge), and save_len holds.
- Upload read:
  - ioctl_din = buffer[ioctl_addr[AW-1:0]], with 1-clock latency, independent of ce.
  - Addresses ≥ save_len return 0x00.
- Capture and upload happening together is allowed: the dual-port buffer takes writes on port A and reads on port B. A same-address collision returns the old data.
- Reset mid-byte: everything clears; buffer contents are undefined and save_len=0 marks them invalid.

Decomposition:
- Shared package (tape_pkg): state enum IDLE/LEADER/DATA/DONE, the pulse class enum GLITCH/ZERO/ONE/GAP, and the default threshold constants.
- One sub-module, tape_pulse_classifier: synchronizer, edge detect, period counter, gap timer. It emits a one-clock strobe plus a 2-bit class.
- Buffer reuses the existing dpr memory block.

Test Plan:
- motor↑, 256 periods of 1000 ticks, one period of 3000, then the bits of 0xA5 and 0x3C (0 = 1000, 1 = 3000), then a 6000-tick silence -> save_len=2, buffer[0]=0xA5, buffer[1]=0x3C, save_done=1.
- Leader of only 100 zeros, then 1-bits -> stays in LEADER, save_len=0, save_done=0.
- Valid stream with 50-tick mic glitches inserted mid-bit -> bytes identical to the clean run.
- AW=4, 20 bytes sent -> save_len=16, overflow=1, buffer holds the first 16 bytes.
- Gap after 5 bits of the third byte -> save_len=2, partial byte discarded; upload of addr 0..2 returns byte0, byte1, 0x00.
- reset asserted low mid-DATA -> all outputs 0 within 0 clocks (async); after release, a motor↑ is required before capture resumes.

Source files
------------

// File: rtl/tape_pkg.sv
// tape_pkg: recorder states, pulse classes and default period thresholds
package tape_pkg;
  typedef enum logic [1:0] {IDLE, LEADER, DATA, DONE} state_t;
  typedef enum logic [1:0] {GLITCH, ZERO, ONE, GAP} pulse_t;
  localparam int DEF_AW = 16;
  localparam int DEF_MIN_T = 200;
  localparam int DEF_ZERO_MAX = 2400;
  localparam int DEF_ONE_MAX = 4800;
  localparam int DEF_LEADER_N = 256;
endpackage

// File: rtl/tape_pulse_classifier.sv
// tape_pulse_classifier: syncs mic, times full-cycle periods in ce ticks and emits a class strobe
module tape_pulse_classifier
  import tape_pkg::*;
#(
  parameter int MIN_T = DEF_MIN_T,
  parameter int ZERO_MAX = DEF_ZERO_MAX,
  parameter int ONE_MAX = DEF_ONE_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       mic,
  output logic       stb,
  output logic [1:0] cls
);
  logic [1:0] sync;
  logic [15:0] cnt;
  logic prev, armed, rise, glitch, gap_hit;
  always_comb begin
    rise = ce && sync[1] && !prev;
    glitch = cnt < 16'(MIN_T);
    gap_hit = ce && !rise && armed && cnt == 16'(ONE_MAX - 1);
  end
  // glitch edges leave the running period untouched so the real edge still measures the full cycle
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync <= '0;
      prev <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
      stb <= 1'b0;
      cls <= GLITCH;
    end else begin
      sync <= {sync[0], mic};
      stb <= rise || gap_hit;
      cls <= gap_hit ? GAP : glitch ? GLITCH : cnt < 16'(ZERO_MAX) ? ZERO : cnt < 16'(ONE_MAX) ? ONE : GAP;
      if (ce) begin
        prev <= sync[1];
        cnt <= (rise && !glitch) ? '0 : (cnt == 16'hFFFF ? cnt : cnt + 16'd1);
        armed <= (rise && !glitch) ? 1'b1 : (gap_hit ? 1'b0 : armed);
      end
    end
endmodule

// File: rtl/tape_recorder.sv
// tape_recorder: captures the CPU tape-out waveform into a byte buffer readable over ioctl upload
module tape_recorder
  import tape_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int MIN_T = DEF_MIN_T,
  parameter int ZERO_MAX = DEF_ZERO_MAX,
  parameter int ONE_MAX = DEF_ONE_MAX,
  parameter int LEADER_N = DEF_LEADER_N
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        mic,
  input  logic        motor,
  input  logic        ioctl_upload,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic [AW:0] save_len,
  output logic        save_done,
  output logic        overflow
);
  localparam int LW = $clog2(LEADER_N + 1);
  state_t state;
  pulse_t pc;
  logic [1:0] cls;
  logic stb, motor_q, bit_ok, byte_end, wr;
  logic [LW-1:0] lcnt;
  logic [2:0] bcnt;
  logic [6:0] sh;
  logic [7:0] mem [2**AW];
  tape_pulse_classifier #(.MIN_T(MIN_T), .ZERO_MAX(ZERO_MAX), .ONE_MAX(ONE_MAX)) u_cls (
    .clock, .reset, .ce, .mic, .stb, .cls
  );
  always_comb begin
    pc = pulse_t'(cls);
    bit_ok = stb && (pc == ZERO || pc == ONE);
    byte_end = bit_ok && state == DATA && bcnt == 3'd7;
    wr = byte_end && !save_len[AW];
  end
  always_ff @(posedge clock)
    if (wr) mem[save_len[AW-1:0]] <= {sh, pc == ONE};
  // read port sees the pre-write byte on a same-address collision
  always_ff @(posedge clock or negedge reset)
    if (!reset) ioctl_din <= '0;
    else ioctl_din <= (ioctl_upload && ioctl_addr < 25'(save_len)) ? mem[ioctl_addr[AW-1:0]] : 8'h00;
  // motor_q resets high so a motor already on at reset release does not restart capture
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      motor_q <= 1'b1;
      lcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      save_len <= '0;
      save_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      motor_q <= motor;
      if (!motor) state <= IDLE;
      else case (state)
        IDLE: if (!motor_q) begin
          state <= LEADER;
          lcnt <= '0;
          save_len <= '0;
          save_done <= 1'b0;
          overflow <= 1'b0;
        end
        LEADER: if (stb) begin
          if (pc == ZERO) lcnt <= lcnt == LW'(LEADER_N) ? lcnt : lcnt + 1'b1;
          else if (pc == ONE && lcnt == LW'(LEADER_N)) begin
            state <= DATA;
            bcnt <= '0;
          end else if (pc != GLITCH) lcnt <= '0;
        end
        DATA: if (bit_ok) begin
          sh <= {sh[5:0], pc == ONE};
          bcnt <= bcnt + 3'd1;
          if (byte_end) begin
            save_len <= wr ? save_len + 1'b1 : save_len;
            overflow <= overflow | !wr;
          end
        end else if (stb && pc == GAP) begin
          state <= DONE;
          save_done <= 1'b1;
        end
        DONE: if (stb && pc == ZERO) begin
          state <= LEADER;
          lcnt <= LW'(1);
        end
      endcase
    end
endmodule

// File: tb/tb_tape_recorder.sv
// tb_tape_recorder: period-level behavioural model of the recorder checked against the DUT
module tb_tape_recorder;
  localparam int AW = 4, CAP = 16, MIN_T = 8, ZERO_MAX = 40, ONE_MAX = 80, LN = 16;
  localparam int T0 = 20, T1 = 60;
  localparam int M_IDLE = 0, M_LEAD = 1, M_DATA = 2, M_DONE = 3;
  localparam int C_ZERO = 1, C_ONE = 2, C_GAP = 3;
  logic clock = 1'b0, reset = 1'b1, ce = 1'b0, mic = 1'b0, motor = 1'b0, ioctl_upload = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_din;
  logic [AW:0] save_len;
  logic save_done, overflow;
  int checks = 0, failures = 0;
  int ms = M_IDLE, lc = 0, nb = 0, mlen = 0, since = 0;
  bit armed = 0, mot = 0, mdone = 0, movf = 0;
  logic [7:0] acc = '0;
  logic [7:0] mm [CAP];
  logic [7:0] d;
  event smp;

  tape_recorder #(.AW(AW), .MIN_T(MIN_T), .ZERO_MAX(ZERO_MAX), .ONE_MAX(ONE_MAX), .LEADER_N(LN)) dut (
    .clock(clock), .reset(reset), .ce(ce), .mic(mic), .motor(motor),
    .ioctl_upload(ioctl_upload), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .save_len(save_len), .save_done(save_done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one classified period applied to the recorder rules
  task automatic mcls(int c);
    case (ms)
      M_LEAD:
        if (c == C_ZERO) lc = lc < LN ? lc + 1 : LN;
        else if (c == C_ONE && lc >= LN) begin ms = M_DATA; nb = 0; end
        else lc = 0;
      M_DATA:
        if (c == C_GAP) begin ms = M_DONE; mdone = 1; end
        else begin
          acc = {acc[6:0], c == C_ONE};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (mlen == CAP) movf = 1;
            else begin mm[mlen] = acc; mlen++; end
          end
        end
      M_DONE: if (c == C_ZERO) begin ms = M_LEAD; lc = 1; end
      default: ;
    endcase
  endtask

  task automatic edge_ev();
    if (since < MIN_T) return;
    mcls(since < ZERO_MAX ? C_ZERO : since < ONE_MAX ? C_ONE : C_GAP);
    since = 0;
    armed = 1;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      ce = 1'b1; @(posedge clock); #1;
      ce = 1'b0; @(posedge clock); #1;
      since++;
      if (armed && since == ONE_MAX) begin armed = 0; mcls(C_GAP); end
    end
  endtask

  always @(smp) begin
    check("save_len", int'(save_len), mlen);
    check("save_done", int'(save_done), int'(mdone));
    check("overflow", int'(overflow), int'(movf));
  end

  task automatic per(int p, bit g);
    mic = 1'b1; edge_ev();
    if (g) begin
      tick(2); mic = 1'b0; tick(2); mic = 1'b1; edge_ev(); tick(p / 2 - 4);
    end else tick(p / 2);
    ->smp;
    mic = 1'b0; tick(p - p / 2);
  endtask

  task automatic leader(int n);
    repeat (n) per(T0, 0);
  endtask

  task automatic sbyte(logic [7:0] b, bit g);
    for (int i = 7; i >= 0; i--) per(b[i] ? T1 : T0, g);
  endtask

  task automatic close_gap();
    mic = 1'b1; edge_ev(); tick(5); ->smp;
    mic = 1'b0; tick(ONE_MAX + 40); ->smp;
  endtask

  task automatic set_motor(bit v);
    if (v && !mot) begin ms = M_LEAD; mlen = 0; mdone = 0; movf = 0; lc = 0; end
    if (!v) ms = M_IDLE;
    mot = v; motor = v;
    tick(3);
  endtask

  task automatic rd(input int a, output logic [7:0] q);
    ioctl_upload = 1'b1; ioctl_addr = 25'(a);
    @(posedge clock); #1;
    q = ioctl_din;
    check("upload", int'(q), a < mlen ? int'(mm[a % CAP]) : 0);
  endtask

  task automatic session();
    set_motor(0); set_motor(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check("rst_din", int'(ioctl_din), 0);
    check("rst_len", int'(save_len), 0);
    check("rst_done", int'(save_done), 0);
    check("rst_ovf", int'(overflow), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    tick(100);
    // clean capture of two bytes, then a second block appended in the same session
    set_motor(1);
    leader(20); per(T1, 0); sbyte(8'hA5, 0); sbyte(8'h3C, 0); close_gap();
    check("t1_len", int'(save_len), 2);
    check("t1_done", int'(save_done), 1);
    rd(0, d); check("t1_b0", int'(d), 8'hA5);
    rd(1, d); check("t1_b1", int'(d), 8'h3C);
    rd(2, d); check("t1_b2", int'(d), 0);
    leader(20); per(T1, 0); sbyte(8'h5A, 0); close_gap();
    check("t1_len_app", int'(save_len), 3);
    check("t1_done_app", int'(save_done), 1);
    rd(2, d); check("t1_b2_app", int'(d), 8'h5A);
    // short leader never qualifies
    session();
    leader(10); repeat (10) per(T1, 0); close_gap();
    check("t2_len", int'(save_len), 0);
    check("t2_done", int'(save_done), 0);
    // glitches inside every bit
    session();
    leader(20); per(T1, 1); sbyte(8'hA5, 1); sbyte(8'h3C, 1); close_gap();
    check("t3_len", int'(save_len), 2);
    rd(0, d); check("t3_b0", int'(d), 8'hA5);
    rd(1, d); check("t3_b1", int'(d), 8'h3C);
    // overflow of a 16-byte buffer
    session();
    leader(20); per(T1, 0);
    for (int i = 0; i < 20; i++) sbyte(8'(i * 37 + 11), 0);
    close_gap();
    check("t4_len", int'(save_len), 16);
    check("t4_ovf", int'(overflow), 1);
    for (int a = 0; a < 18; a++) rd(a, d);
    rd(0, d); check("t4_b0", int'(d), 8'h0B);
    rd(15, d); check("t4_b15", int'(d), 8'h36);
    rd(16, d); check("t4_b16", int'(d), 0);
    // partial third byte discarded
    session();
    leader(20); per(T1, 0); sbyte(8'hC3, 0); sbyte(8'h7E, 0);
    per(T1, 0); per(T0, 0); per(T1, 0); per(T1, 0); per(T0, 0);
    close_gap();
    check("t5_len", int'(save_len), 2);
    check("t5_ovf", int'(overflow), 0);
    rd(0, d); check("t5_b0", int'(d), 8'hC3);
    rd(1, d); check("t5_b1", int'(d), 8'h7E);
    rd(2, d); check("t5_b2", int'(d), 0);
    // asynchronous reset in the middle of a byte
    session();
    leader(20); per(T1, 0); sbyte(8'hE1, 0);
    per(T0, 0); per(T1, 0); per(T0, 0);
    rd(0, d); check("t6_pre", int'(d), 8'hE1);
    #2 reset = 1'b0; mic = 1'b0;
    #1;
    check("t6_din", int'(ioctl_din), 0);
    check("t6_len", int'(save_len), 0);
    check("t6_done", int'(save_done), 0);
    check("t6_ovf", int'(overflow), 0);
    ms = M_IDLE; lc = 0; nb = 0; mlen = 0; mdone = 0; movf = 0; since = 0; armed = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick(100);
    leader(20); per(T1, 0); sbyte(8'h96, 0); close_gap();
    check("t6_nocap", int'(save_len), 0);
    session();
    leader(20); per(T1, 0); sbyte(8'h96, 0); close_gap();
    check("t6_len2", int'(save_len), 1);
    check("t6_done2", int'(save_done), 1);
    rd(0, d); check("t6_b0", int'(d), 8'h96);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
